// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file geometry, controller state type and index helper
package regfile_wb_arbiter_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;
    typedef enum logic {ST_INIT, ST_RUN} state_e;
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests in, register-file write port out
//  re_init        sweep restart pulse
//  req_valid      per-requester pending write
//  req_reg        per-requester dest reg, slice [i*ADDR_W +: ADDR_W]
//  req_data       per-requester data, slice [i*DATA_W +: DATA_W]
//  req_ready      one-hot grant
//  reg_write      register file write enable
//  write_register register file write address
//  write_data     register file write data
//  init_done      high once the zero sweep has finished
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) ();
    logic                      re_init;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      reg_write;
    logic [ADDR_W-1:0]         write_register;
    logic [DATA_W-1:0]         write_data;
    logic                      init_done;
    modport master (
        output re_init, req_valid, req_reg, req_data,
        input  req_ready, reg_write, write_register, write_data, init_done
    );
    modport slave (
        input  re_init, req_valid, req_reg, req_data,
        output req_ready, reg_write, write_register, write_data, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr and wraps
//  valid  request vector
//  ptr    highest-priority index this cycle
//  grant  one-hot winner, zero when nothing is valid
//  winner encoded winner index
//  any    some request was valid
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);
    logic [IDX_W-1:0] idx;
    // Scanning from the farthest offset down lets the nearest valid index overwrite earlier hits.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (valid[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
        grant = any ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the register-file write port; zero sweep after reset, then round-robin writeback
//  clk    clock, rising edge
//  rst_n  asynchronous active-low reset
//  bus    slave side of regfile_wb_arbiter_if (requests in, write port out)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              init_done_q, init_done_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic               any;
    logic [ADDR_W-1:0]  win_reg;
    logic [DATA_W-1:0]  win_data;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid  (bus.req_valid),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );
    assign win_reg  = bus.req_reg[winner*ADDR_W +: ADDR_W];
    assign win_data = bus.req_data[winner*DATA_W +: DATA_W];
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        wr_en_d       = 1'b0;
        wr_reg_d      = wr_reg_q;
        wr_data_d     = wr_data_q;
        init_done_d   = 1'b0;
        bus.req_ready = '0;
        if (state_q == ST_INIT) begin
            if (bus.re_init) begin
                cnt_d = '0;
            end else begin
                wr_en_d   = 1'b1;
                wr_reg_d  = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = ST_RUN;
            end
        end else if (bus.re_init) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else begin
            init_done_d = 1'b1;
            // Granting waits for init_done so no requester is served while reg 31 is still going out.
            if (init_done_q && any) begin
                bus.req_ready = grant;
                ptr_d         = IDX_W'(wrap_inc(int'(winner), NUM_REQ));
                // Writes to reg 0 are accepted but dropped so it stays zero.
                if (win_reg != '0) begin
                    wr_en_d   = 1'b1;
                    wr_reg_d  = win_reg;
                    wr_data_d = win_data;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end
    assign bus.reg_write      = wr_en_q;
    assign bus.write_register = wr_reg_q;
    assign bus.write_data     = wr_data_q;
    assign bus.init_done      = init_done_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the writeback arbiter against a behavioural model
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    regfile_wb_arbiter_if #(.NUM_REQ(N)) bus ();
    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    int n_tests = 0;
    int n_fail  = 0;
    bit m_run, m_done;
    int m_cnt, m_last;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_data;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Served-longest-ago first: distance measured from the requester just after the last winner.
    function automatic int rr_pick(input logic [N-1:0] v);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - m_last - 1 + 2 * N) % N;
            if (v[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction
    task automatic model_reset();
        m_run = 0; m_done = 0; m_cnt = 0; m_last = N - 1;
        exp_we = 0; exp_reg = '0; exp_data = '0;
    endtask
    task automatic drive(input logic re, input logic [N-1:0] v,
                         input logic [N*ADDR_W-1:0] r, input logic [N*DATA_W-1:0] d);
        bus.re_init = re; bus.req_valid = v; bus.req_reg = r; bus.req_data = d;
    endtask
    // One clock: check outputs mid-cycle, advance the model, return at posedge+1 ready for new inputs.
    task automatic cycle(output logic [N-1:0] got);
        int w;
        logic [N-1:0] er;
        logic [ADDR_W-1:0] rv;
        @(negedge clk);
        w = (m_run && m_done && !bus.re_init) ? rr_pick(bus.req_valid) : -1;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        got = bus.req_ready;
        check("req_ready", bus.req_ready, er);
        check("reg_write", bus.reg_write, exp_we);
        check("write_register", bus.write_register, exp_reg);
        check("write_data", bus.write_data, exp_data);
        check("init_done", bus.init_done, m_done);
        if (!m_run) begin
            m_done = 0;
            if (bus.re_init) begin
                m_cnt = 0; exp_we = 0;
            end else begin
                exp_we = 1; exp_reg = ADDR_W'(m_cnt); exp_data = '0;
                if (m_cnt == NUM_REGS - 1) m_run = 1;
                m_cnt++;
            end
        end else if (bus.re_init) begin
            m_run = 0; m_cnt = 0; exp_we = 0; m_done = 0;
        end else begin
            m_done = 1; exp_we = 0;
            if (w >= 0) begin
                m_last = w;
                rv = bus.req_reg[w*ADDR_W +: ADDR_W];
                if (rv != 0) begin
                    exp_we = 1; exp_reg = rv; exp_data = bus.req_data[w*DATA_W +: DATA_W];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [N-1:0] got;
        bit pend [N];
        int waitc [N];
        logic [ADDR_W-1:0] preg [N];
        logic [DATA_W-1:0] pdat [N];
        drive(0, '0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_write", bus.reg_write, 0);
        check("rst_write_register", bus.write_register, 0);
        check("rst_write_data", bus.write_data, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst_req_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        // Sweep with all requesters pending: no grant may leak out during INIT.
        drive(0, 3'b111, {5'd7, 5'd6, 5'd5}, {32'hCCCC0007, 32'hBBBB0006, 32'hAAAA0005});
        repeat (33) cycle(got);
        for (int k = 0; k < 6; k++) begin
            cycle(got);
            check("rr_order", got, 3'b001 << (k % 3));
        end
        drive(0, 3'b010, '0, {32'h0, 32'hDEADBEEF, 32'h0});
        cycle(got);
        check("reg0_grant", got, 3'b010);
        drive(0, '0, '0, '0);
        check("reg0_dropped", bus.reg_write, 0);
        drive(0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77777777, 64'h0});
        cycle(got);
        check("pre_reinit_write", bus.reg_write, 1);
        check("pre_reinit_reg", bus.write_register, 7);
        drive(1, 3'b001, {10'd0, 5'd9}, {64'h0, 32'h12345678});
        cycle(got);
        check("reinit_no_grant", got, 0);
        drive(0, '0, '0, '0);
        repeat (17) cycle(got);
        check("mid_sweep_reg", bus.write_register, 16);
        rst_n = 1'b0;
        #1;
        check("async_reg_write", bus.reg_write, 0);
        check("async_write_register", bus.write_register, 0);
        check("async_init_done", bus.init_done, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (34) cycle(got);
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; waitc[i] = 0; preg[i] = '0; pdat[i] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1; waitc[i] = 0;
                    preg[i] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, NUM_REGS - 1));
                    pdat[i] = $urandom;
                end
                bus.req_valid[i] = pend[i];
                bus.req_reg[i*ADDR_W +: ADDR_W] = preg[i];
                bus.req_data[i*DATA_W +: DATA_W] = pdat[i];
            end
            bus.re_init = ($urandom_range(0, 999) == 0);
            cycle(got);
            if (got != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (got[i]) begin
                        check("fair_wait", waitc[i] < N, 1);
                        pend[i] = 0;
                    end else if (pend[i]) begin
                        waitc[i]++;
                    end
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
